// File: rtl/calc_param.sv
// calc_param: BCD-keyed four-function decimal calculator.
// Commands arrive over a valid/ready handshake. Add and subtract take one cycle.
// Multiply uses a shift-add datapath and takes WIDTH cycles. Division also takes
// WIDTH cycles and exists only when the macro CALC_DIV_EN is defined.
// Each displayed value is serialised one decimal digit per cycle, least significant first.
module calc_param #(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 27
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                i_cmd,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  output logic [1:0]                o_status,
  output logic [3:0]                o_data,
  output logic [$clog2(DIGITS)-1:0] o_pos,
  output logic                      o_data_valid,
  output logic [2:0]                o_ea
);

  localparam int PW = $clog2(DIGITS);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

  function automatic logic [WIDTH-1:0] pow10(input int n);
    logic [WIDTH-1:0] v;
    v = WIDTH'(1);
    for (int i = 0; i < n; i++) v = v * TEN;
    return v;
  endfunction

  // Largest displayable value, and the smallest entry that already fills the display
  localparam logic [WIDTH-1:0] MAXV = pow10(DIGITS) - WIDTH'(1);
  localparam logic [WIDTH-1:0] LIM  = pow10(DIGITS - 1);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    ESPERA_A = 3'b000,
    ESPERA_B = 3'b001,
    CALC     = 3'b010,
    PRINT    = 3'b011,
    ERRO     = 3'b100
  } state_t;

  state_t r_state, w_state_nxt, r_ret, w_ret_nxt;

  logic [WIDTH-1:0]   r_entry, r_a, r_b, r_pval;
  logic               r_fresh;
  logic [1:0]         r_op;
  logic [PW-1:0]      r_pos;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0]   r_mplier;
`ifdef CALC_DIV_EN
  logic [WIDTH-1:0]   r_rem, r_quo;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;
`endif

  logic               w_accept, w_is_digit, w_is_op, w_is_eq, w_is_bs;
  logic [1:0]         w_cmd_op;
  logic               w_fresh_a, w_dig_ok;
  logic [WIDTH-1:0]   w_dig_val, w_bs_val;
  logic               w_do_digit, w_do_bs, w_do_op, w_do_opswap, w_do_eq;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last, w_calc_done, w_calc_err;
  logic [WIDTH-1:0]   w_res;

  // Command decode
  assign w_accept   = i_cmd_valid && o_cmd_ready;
  assign w_is_digit = (i_cmd <= 4'd9);
  assign w_is_eq    = (i_cmd == 4'd14);
  assign w_is_bs    = (i_cmd == 4'd15);
`ifdef CALC_DIV_EN
  assign w_is_op    = (i_cmd >= 4'd10) && (i_cmd <= 4'd13);
`else
  assign w_is_op    = (i_cmd >= 4'd10) && (i_cmd <= 4'd12);
`endif
  assign w_cmd_op   = 2'(i_cmd - 4'd10);

  // A digit right after a result starts a new number instead of extending the result
  assign w_fresh_a  = r_fresh && (r_state == ESPERA_A);
  assign w_dig_ok   = w_fresh_a || (r_entry < LIM);
  assign w_dig_val  = w_fresh_a ? WIDTH'(i_cmd) : (r_entry * TEN + WIDTH'(i_cmd));
  assign w_bs_val   = r_entry / TEN;

  // Arithmetic datapath: next iteration values and final result/error per operation
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
`ifdef CALC_DIV_EN
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_b});
  assign w_rem_nxt = w_ge ? WIDTH'(w_shift - {1'b0, r_b}) : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
`endif

  // Select completion, error and result for the latched operation
  always_comb begin
    w_calc_done = 1'b1;
    w_calc_err  = 1'b0;
    w_res       = '0;
    case (r_op)
      OP_ADD: begin
        w_calc_err = (w_sum > {1'b0, MAXV});
        w_res      = w_sum[WIDTH-1:0];
      end
      OP_SUB: begin
        w_calc_err = (r_a < r_b);
        w_res      = r_a - r_b;
      end
      OP_MUL: begin
        w_calc_done = w_last;
        w_calc_err  = (w_acc_nxt > {{WIDTH{1'b0}}, MAXV});
        w_res       = w_acc_nxt[WIDTH-1:0];
      end
`ifdef CALC_DIV_EN
      OP_DIV: begin
        w_calc_done = w_last;
        w_calc_err  = (r_b == '0);
        w_res       = w_quo_nxt;
      end
`endif
      default: begin
        w_calc_done = 1'b1;
      end
    endcase
  end

  // State register with return-state memory for PRINT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ESPERA_A;
      r_ret   <= ESPERA_A;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
    end
  end

  // Next-state logic and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_do_digit  = 1'b0;
    w_do_bs     = 1'b0;
    w_do_op     = 1'b0;
    w_do_opswap = 1'b0;
    w_do_eq     = 1'b0;
    case (r_state)
      ESPERA_A: begin
        if (w_accept) begin
          if (w_is_digit && w_dig_ok) begin
            w_do_digit  = 1'b1;
            w_state_nxt = PRINT;
            w_ret_nxt   = ESPERA_A;
          end else if (w_is_bs) begin
            w_do_bs     = 1'b1;
            w_state_nxt = PRINT;
            w_ret_nxt   = ESPERA_A;
          end else if (w_is_op) begin
            w_do_op     = 1'b1;
            w_state_nxt = PRINT;
            w_ret_nxt   = ESPERA_B;
          end
        end
      end
      ESPERA_B: begin
        if (w_accept) begin
          if (w_is_digit && w_dig_ok) begin
            w_do_digit  = 1'b1;
            w_state_nxt = PRINT;
            w_ret_nxt   = ESPERA_B;
          end else if (w_is_bs) begin
            w_do_bs     = 1'b1;
            w_state_nxt = PRINT;
            w_ret_nxt   = ESPERA_B;
          end else if (w_is_op) begin
            w_do_opswap = 1'b1;
          end else if (w_is_eq) begin
            w_do_eq     = 1'b1;
            w_state_nxt = CALC;
          end
        end
      end
      CALC: begin
        if (w_calc_done) begin
          w_state_nxt = w_calc_err ? ERRO : PRINT;
          w_ret_nxt   = ESPERA_A;
        end
      end
      PRINT: begin
        if (r_pos == PW'(DIGITS - 1)) w_state_nxt = r_ret;
      end
      ERRO: ;
      default: w_state_nxt = ESPERA_A;
    endcase
  end

  // Operand, entry, iteration and print registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_entry  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_fresh  <= 1'b0;
      r_pval   <= '0;
      r_pos    <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
`ifdef CALC_DIV_EN
      r_rem    <= '0;
      r_quo    <= '0;
`endif
    end else begin
      case (r_state)
        ESPERA_A, ESPERA_B: begin
          if (w_do_digit) begin
            r_entry <= w_dig_val;
            r_fresh <= 1'b0;
            r_pval  <= w_dig_val;
            r_pos   <= '0;
          end else if (w_do_bs) begin
            r_entry <= w_bs_val;
            r_fresh <= 1'b0;
            r_pval  <= w_bs_val;
            r_pos   <= '0;
          end else if (w_do_op) begin
            r_a     <= r_entry;
            r_op    <= w_cmd_op;
            r_entry <= '0;
            r_fresh <= 1'b0;
            r_pval  <= '0;
            r_pos   <= '0;
          end else if (w_do_opswap) begin
            r_op    <= w_cmd_op;
          end else if (w_do_eq) begin
            r_b      <= r_entry;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, r_a};
            r_mplier <= r_entry;
`ifdef CALC_DIV_EN
            r_rem    <= '0;
            r_quo    <= r_a;
`endif
          end
        end
        CALC: begin
          r_cnt    <= r_cnt + CW'(1);
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
`ifdef CALC_DIV_EN
          r_rem    <= w_rem_nxt;
          r_quo    <= w_quo_nxt;
`endif
          if (w_calc_done && !w_calc_err) begin
            r_entry <= w_res;
            r_fresh <= 1'b1;
            r_pval  <= w_res;
            r_pos   <= '0;
          end
        end
        PRINT: begin
          r_pval <= r_pval / TEN;
          r_pos  <= r_pos + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Status and display outputs decoded from the current state
  always_comb begin
    o_cmd_ready  = (r_state == ESPERA_A) || (r_state == ESPERA_B);
    o_data_valid = (r_state == PRINT);
    o_pos        = (r_state == PRINT) ? r_pos : '0;
    o_data       = (r_state == PRINT) ? 4'(r_pval % TEN) : 4'd0;
    o_ea         = r_state;
    case (r_state)
      ESPERA_A, ESPERA_B: o_status = 2'b10;
      CALC:               o_status = 2'b01;
      PRINT:              o_status = 2'b11;
      default:            o_status = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_calc_param.sv
// Testbench for calc_param: directed test-plan steps followed by random key sequences,
// all compared against a decimal-arithmetic reference model of the calculator.
module tb_calc_param;
  localparam int DIGITS = 8;
  localparam int WIDTH  = 27;
  localparam int PW     = $clog2(DIGITS);
`ifdef CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    status;
  logic [3:0]    data;
  logic [PW-1:0] pos;
  logic          data_valid;
  logic [2:0]    ea;

  calc_param #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .i_cmd(cmd), .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready), .o_status(status), .o_data(data), .o_pos(pos),
    .o_data_valid(data_valid), .o_ea(ea)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 ESPERA_A, 1 ESPERA_B, 4 ERRO (CALC/PRINT are transient)
  int              m_st;
  longint unsigned m_entry, m_a;
  int              m_op;
  bit              m_fresh;

  function automatic longint unsigned p10(input int n);
    longint unsigned v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

  function automatic int ndig(input longint unsigned v);
    int n = 0;
    while (v != 0) begin v = v / 10; n++; end
    return n;
  endfunction

  function automatic int digit_of(input longint unsigned v, input int k);
    return int'((v / p10(k)) % 10);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int st);
    chk("idle_status", 64'(status), 64'd2);
    chk("idle_ready", 64'(cmd_ready), 64'd1);
    chk("idle_ea", 64'(ea), 64'(st));
    chk("idle_dv", 64'(data_valid), 64'd0);
  endtask

  task automatic check_print(input longint unsigned v, input int ret, input bit poke);
    for (int k = 0; k < DIGITS; k++) begin
      @(negedge clock);
      if (poke) begin
        cmd       = 4'd7;
        cmd_valid = (k < DIGITS - 1);
      end
      chk("prt_dv", 64'(data_valid), 64'd1);
      chk("prt_pos", 64'(pos), 64'(k));
      chk("prt_data", 64'(data), 64'(digit_of(v, k)));
      chk("prt_status", 64'(status), 64'd3);
      chk("prt_ready", 64'(cmd_ready), 64'd0);
    end
    m_st = ret;
    @(negedge clock);
    check_idle(ret);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_ea", 64'(ea), 64'd0);
    chk("rst_status", 64'(status), 64'd2);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_pos", 64'(pos), 64'd0);
    chk("rst_dv", 64'(data_valid), 64'd0);
    @(negedge clock);
    reset   = 1'b0;
    m_st    = 0;
    m_entry = 0;
    m_a     = 0;
    m_op    = 10;
    m_fresh = 1'b0;
  endtask

  function automatic bit is_op(input int c);
    return (c >= 10 && c <= 12) || (c == 13 && DIV_EN);
  endfunction

  // Present one command, then follow the model's prediction of what the DUT shows
  task automatic send(input int c, input bit poke);
    longint unsigned b, r;
    bit err;
    int lat;
    @(negedge clock);
    chk("ready", 64'(cmd_ready), 64'd1);
    cmd       = 4'(c);
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    if (c <= 9) begin
      if (m_st == 0 && m_fresh) begin
        m_entry = longint'(c);
        m_fresh = 1'b0;
        check_print(m_entry, 0, poke);
      end else if (ndig(m_entry) >= DIGITS) begin
        @(negedge clock);
        check_idle(m_st);
      end else begin
        m_entry = m_entry * 10 + longint'(c);
        check_print(m_entry, m_st, poke);
      end
    end else if (c == 15) begin
      m_entry = m_entry / 10;
      m_fresh = 1'b0;
      check_print(m_entry, m_st, poke);
    end else if (is_op(c)) begin
      m_op = c;
      if (m_st == 0) begin
        m_a     = m_entry;
        m_entry = 0;
        m_fresh = 1'b0;
        check_print(0, 1, poke);
      end else begin
        @(negedge clock);
        check_idle(1);
      end
    end else if (c == 14 && m_st == 1) begin
      b   = m_entry;
      err = 1'b0;
      r   = 0;
      lat = 1;
      case (m_op)
        10: r = m_a + b;
        11: begin err = (m_a < b); r = err ? 0 : m_a - b; end
        12: begin r = m_a * b; lat = WIDTH; end
        default: begin err = (b == 0); r = err ? 0 : m_a / b; lat = WIDTH; end
      endcase
      if (r > p10(DIGITS) - 1) err = 1'b1;
      for (int k = 0; k < lat; k++) begin
        @(negedge clock);
        chk("calc_status", 64'(status), 64'd1);
        chk("calc_ea", 64'(ea), 64'd2);
      end
      if (err) begin
        @(negedge clock);
        chk("err_status", 64'(status), 64'd0);
        chk("err_ea", 64'(ea), 64'd4);
        chk("err_ready", 64'(cmd_ready), 64'd0);
        m_st = 4;
      end else begin
        m_entry = r;
        m_fresh = 1'b1;
        check_print(r, 0, 1'b0);
      end
    end else begin
      @(negedge clock);
      check_idle(m_st);
    end
  endtask

  task automatic send_seq(input int s[$]);
    foreach (s[i]) send(s[i], 1'b0);
  endtask

  initial begin
    int unsigned pick;
    int c;
    reset     = 1'b1;
    cmd       = 4'd0;
    cmd_valid = 1'b0;
    do_reset();

    // Digit entry and backspace
    send_seq('{1, 2, 3});
    send(15, 1'b0);
    send_seq('{15, 15});

    // 123 + 77 = 200
    send_seq('{1, 2, 3, 10, 7, 7, 14});

    // New number after result, 9999 x 9999, then chained x 2 overflows
    send_seq('{9, 9, 9, 9, 12, 9, 9, 9, 9, 14});
    send_seq('{12, 2, 14});
    @(negedge clock);
    cmd = 4'd1;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("erro_hold_ea", 64'(ea), 64'd4);
    chk("erro_hold_status", 64'(status), 64'd0);
    do_reset();

    // 5 - 7 -> error
    send_seq('{5, 11, 7, 14});
    do_reset();

    // Reset during the print of a valid result
    send_seq('{3, 10, 4});
    @(negedge clock);
    cmd = 4'd14;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    chk("mid_calc_ea", 64'(ea), 64'd2);
    @(negedge clock);
    chk("mid_prt_status", 64'(status), 64'd3);
    chk("mid_prt_data", 64'(data), 64'd7);
    @(negedge clock);
    chk("mid_prt_pos", 64'(pos), 64'd1);
    do_reset();
    @(negedge clock);
    check_idle(0);
    send(5, 1'b0);
    do_reset();

    // Division (or cmd 13 ignored when the divider is absent)
    send_seq('{1, 0, 0, 13, 7, 14});
    send_seq('{5, 13, 0, 14});
    do_reset();
    send_seq('{5, 10, 13, 2, 14});
    do_reset();

    // Nine digits: the ninth is ignored; keys pressed during a print are dropped
    send_seq('{1, 2, 3, 4});
    send(5, 1'b1);
    send_seq('{6, 7, 8, 9});
    send(15, 1'b0);
    do_reset();

    // Random key sequences
    for (int i = 0; i < 150; i++) begin
      if (m_st == 4) do_reset();
      pick = $urandom_range(99, 0);
      if (pick < 55)      c = int'($urandom_range(9, 0));
      else if (pick < 65) c = 15;
      else if (pick < 85) c = int'($urandom_range(13, 10));
      else                c = 14;
      send(c, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
